// File: rtl/fc_neuron_pkg.sv
// fc_neuron_pkg: shared FSM state type, Q-format width and saturation limits
package fc_neuron_pkg;
    localparam int Q_W = 16;
    localparam logic signed [Q_W-1:0] MIN_Q = 16'sh8000;
    localparam logic signed [Q_W-1:0] MAX_Q = 16'sh7FFF;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_BIAS, ST_EMIT} state_t;
endpackage

// File: rtl/fc_neuron_sat_shift.sv
// sat_shift: arithmetic right shift by FRAC (floor) then saturate to the Q-format range
module sat_shift
    import fc_neuron_pkg::*;
#(
    parameter int IN_W = 34,
    parameter int FRAC = 8
) (
    input  logic signed [IN_W-1:0] din,
    output logic signed [Q_W-1:0]  dout,
    output logic                   sat
);
    logic signed [IN_W-1:0] shifted;
    always_comb begin
        shifted = din >>> FRAC;
        sat = !(&shifted[IN_W-1:Q_W-1] || !(|shifted[IN_W-1:Q_W-1]));
        dout = sat ? (shifted[IN_W-1] ? MIN_Q : MAX_Q) : shifted[Q_W-1:0];
    end
endmodule

// File: rtl/fc_neuron.sv
// fc_neuron: multiply-accumulate of N_IN samples, bias add, shift and saturate
module fc_neuron
    import fc_neuron_pkg::*;
#(
    parameter int N_IN = 16,
    parameter int FRAC = 8,
    parameter logic signed [15:0] BIAS = 16'sd0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               din_valid,
    input  logic signed [15:0] din,
    input  logic signed [15:0] weight,
    output logic               busy,
    output logic               out_valid,
    output logic signed [15:0] out_data,
    output logic               sat
);
    localparam int ACC_W = 32 + $clog2(N_IN);
    localparam int CNT_W = $clog2(N_IN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN);
    localparam logic signed [ACC_W-1:0] BIAS_ACC = ACC_W'(BIAS) <<< FRAC;
    state_t state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic signed [31:0] prod_q, prod_d;
    logic pend_q, pend_d;
    logic busy_q, busy_d;
    logic out_valid_q, out_valid_d;
    logic signed [Q_W-1:0] out_data_q, out_data_d;
    logic sat_q, sat_d;
    logic signed [Q_W-1:0] res;
    logic res_sat;
    sat_shift #(.IN_W(ACC_W), .FRAC(FRAC)) u_sat_shift (
        .din (acc_q),
        .dout(res),
        .sat (res_sat)
    );
    always_comb begin
        state_d = state_q;
        acc_d = pend_q ? acc_q + ACC_W'(prod_q) : acc_q;
        cnt_d = cnt_q;
        prod_d = prod_q;
        pend_d = 1'b0;
        busy_d = busy_q;
        out_valid_d = 1'b0;
        out_data_d = out_data_q;
        sat_d = sat_q;
        unique case (state_q)
            ST_IDLE: if (start) begin
                acc_d = '0;
                cnt_d = '0;
                busy_d = 1'b1;
                state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (din_valid && cnt_q != LAST) begin
                    prod_d = din * weight;
                    pend_d = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
                state_d = (cnt_q == LAST) ? ST_BIAS : ST_ACCUM;
            end
            ST_BIAS: begin
                acc_d = acc_q + BIAS_ACC;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                out_data_d = res;
                sat_d = res_sat;
                out_valid_d = 1'b1;
                busy_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q <= '0;
            cnt_q <= '0;
            prod_q <= '0;
            pend_q <= 1'b0;
            busy_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            sat_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            prod_q <= prod_d;
            pend_q <= pend_d;
            busy_q <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
            sat_q <= sat_d;
        end
    end
    assign busy = busy_q;
    assign out_valid = out_valid_q;
    assign out_data = out_data_q;
    assign sat = sat_q;
endmodule

// File: tb/tb_fc_neuron.sv
// tb_fc_neuron: directed and random inferences on two neurons (bias 0 and -1.0) against an arithmetic model
module tb_fc_neuron;
    localparam int N = 4;
    localparam int FRAC = 8;
    localparam logic signed [15:0] B1 = 16'shFF00;
    typedef logic signed [15:0] vec_t [N];
    typedef struct {int cyc; logic [15:0] d; logic s;} res_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic din_valid = 1'b0;
    logic [15:0] din = '0;
    logic [15:0] weight = '0;
    logic busy0, ov0, sat0, busy1, ov1, sat1;
    logic [15:0] od0, od1;
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    res_t q0[$];
    res_t q1[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ov0) q0.push_back('{cyc, od0, sat0});
        if (ov1) q1.push_back('{cyc, od1, sat1});
    end
    fc_neuron #(.N_IN(N), .FRAC(FRAC), .BIAS(16'sd0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .din_valid(din_valid),
        .din(din), .weight(weight), .busy(busy0), .out_valid(ov0),
        .out_data(od0), .sat(sat0)
    );
    fc_neuron #(.N_IN(N), .FRAC(FRAC), .BIAS(B1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .din_valid(din_valid),
        .din(din), .weight(weight), .busy(busy1), .out_valid(ov1),
        .out_data(od1), .sat(sat1)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [16:0] model(input vec_t d, input vec_t w, input logic signed [15:0] b);
        longint s = 0;
        for (int i = 0; i < N; i++) s += longint'(d[i]) * longint'(w[i]);
        s += longint'(b) * (longint'(1) << FRAC);
        s = s >>> FRAC;
        if (s > 32767) return {1'b1, 16'h7FFF};
        if (s < -32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(s)};
    endfunction
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask
    task automatic feed(input vec_t d, input vec_t w, input int n, input bit gaps, output int k);
        k = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                din_valid = 1'b0;
                din = 16'($urandom);
                start = 1'($urandom_range(0, 1));
                step();
                start = 1'b0;
            end
            din_valid = 1'b1;
            din = d[i];
            weight = w[i];
            step();
            k = cyc;
        end
        if (gaps) begin
            din = 16'($urandom);
            weight = 16'($urandom);
            step();
        end
        din_valid = 1'b0;
        start = 1'b0;
    endtask
    task automatic wait_res(input int k, input logic [16:0] e0, input logic [16:0] e1, input string tag);
        int g = 0;
        res_t r0, r1;
        while ((q0.size() == 0 || q1.size() == 0) && g < 12) begin
            step();
            g++;
        end
        if (q0.size() == 0 || q1.size() == 0) chk({tag, "_timeout"}, 0, 1);
        else begin
            r0 = q0.pop_front();
            r1 = q1.pop_front();
            chk({tag, "_lat0"}, r0.cyc - k, 3);
            chk({tag, "_lat1"}, r1.cyc - k, 3);
            chk({tag, "_data0"}, r0.d, e0[15:0]);
            chk({tag, "_sat0"}, r0.s, e0[16]);
            chk({tag, "_data1"}, r1.d, e1[15:0]);
            chk({tag, "_sat1"}, r1.s, e1[16]);
        end
    endtask
    task automatic run(input vec_t d, input vec_t w, input bit gaps, input logic [16:0] e0, input logic [16:0] e1, input string tag);
        int k;
        do_start();
        chk({tag, "_busy"}, busy0, 1);
        feed(d, w, N, gaps, k);
        wait_res(k, e0, e1, tag);
        repeat (3) step();
        chk({tag, "_hold0"}, {sat0, od0}, e0);
        chk({tag, "_hold1"}, {sat1, od1}, e1);
        chk({tag, "_single"}, q0.size() + q1.size(), 0);
        chk({tag, "_idle"}, busy0, 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        vec_t d, w, d2, w2;
        int k1, k2;
        repeat (2) step();
        chk("rst_busy", busy0, 0);
        chk("rst_ov", ov0, 0);
        chk("rst_data", od0, 0);
        chk("rst_sat", sat0, 0);
        rst_n = 1'b1;
        step();
        foreach (d[i]) begin d[i] = 16'sh0100; w[i] = 16'sh0100; end
        run(d, w, 1'b0, 17'h00400, 17'h00300, "unit");
        foreach (d[i]) begin d[i] = 16'sh0080; w[i] = 16'sh0100; end
        run(d, w, 1'b0, 17'h00200, 17'h00100, "half");
        foreach (d[i]) begin d[i] = 16'sh7FFF; w[i] = 16'sh7FFF; end
        run(d, w, 1'b0, 17'h17FFF, 17'h17FFF, "satpos");
        foreach (d[i]) begin d[i] = 16'sh8000; w[i] = 16'sh7FFF; end
        run(d, w, 1'b0, 17'h18000, 17'h18000, "satneg");
        foreach (d[i]) begin d[i] = 16'sh0100; w[i] = 16'sh0100; end
        run(d, w, 1'b1, 17'h00400, 17'h00300, "gaps");
        do_start();
        feed(d, w, 2, 1'b0, k1);
        rst_n = 1'b0;
        #2;
        chk("abort_busy", busy0, 0);
        chk("abort_data", od0, 0);
        rst_n = 1'b1;
        repeat (6) step();
        chk("abort_nov", q0.size() + q1.size(), 0);
        run(d, w, 1'b0, 17'h00400, 17'h00300, "fresh");
        foreach (d2[i]) begin d2[i] = 16'shFFFF; w2[i] = 16'sh0001; end
        do_start();
        feed(d, w, N, 1'b0, k1);
        repeat (3) step();
        chk("b2b_ov", ov0, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_busy", busy0, 1);
        feed(d2, w2, N, 1'b0, k2);
        wait_res(k1, 17'h00400, 17'h00300, "b2b_first");
        wait_res(k2, 17'h0FFFF, 17'h0FEFF, "b2b_second");
        for (int t = 0; t < 16; t++) begin
            bit full = 1'($urandom_range(0, 1));
            foreach (d[i]) begin
                d[i] = full ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
                w[i] = full ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
            end
            run(d, w, 1'($urandom_range(0, 1)), model(d, w, 16'sd0), model(d, w, B1), "rnd");
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
